// File: rtl/wave_gen_pkg.sv
// Shared definitions for the sine generator / PWM output stage pair:
// FSM encoding, PWM period helper and offset-binary sample-to-duty conversion.
package wave_gen_pkg;

  localparam int unsigned N_FRAC_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } pwm_state_e;

  // Period length in clock cycles for an N_FRAC+1 bit sample.
  function automatic int unsigned pwm_period(input int unsigned n_frac);
    return 32'd1 << (n_frac + 32'd1);
  endfunction

  // Signed two's-complement sample to unsigned duty: invert the sign bit.
  function automatic logic [15:0] to_duty(input logic [15:0] sample, input int unsigned n_frac);
    logic [15:0] mask;
    mask = 16'((32'd1 << (n_frac + 32'd1)) - 32'd1);
    return (sample ^ (16'd1 << n_frac)) & mask;
  endfunction

endpackage

// File: rtl/pwm_output_stage_if.sv
// Sample/request handshake plus PWM status signals between generator side and output stage.
interface pwm_output_stage_if #(
  parameter int unsigned N_FRAC = 7
);

  logic              enable_i;
  logic [N_FRAC:0]   data_i;
  logic              data_valid_strobe_i;
  logic              next_data_strobe_o;
  logic              pwm_o;
  logic              underrun_o;

  modport master (
    output enable_i, data_i, data_valid_strobe_i,
    input  next_data_strobe_o, pwm_o, underrun_o
  );

  modport slave (
    input  enable_i, data_i, data_valid_strobe_i,
    output next_data_strobe_o, pwm_o, underrun_o
  );

endinterface

// File: rtl/pwm_core.sv
// PWM period counter, duty comparator with registered pin, and end-of-period flag.
module pwm_core
  import wave_gen_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         run_i,
  input  logic [W-1:0] duty_i,
  output logic         wrap_c_o,
  output logic         pwm_o
);

  localparam logic [W-1:0] CNT_MAX = W'(pwm_period(W - 1) - 32'd1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         pwm_q, pwm_d;

  // Counter runs free in RUN (natural wrap), parked at zero otherwise.
  always_comb begin
    cnt_d = '0;
    pwm_d = 1'b0;
    if (run_i) begin
      cnt_d = cnt_q + W'(1);
      pwm_d = (cnt_q < duty_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign wrap_c_o = run_i && (cnt_q == CNT_MAX);
  assign pwm_o    = pwm_q;

endmodule

// File: rtl/pwm_output_stage.sv
// PWM output stage: paces the generator, double-buffers samples to period
// boundaries and flags sticky underrun when a period ends without a fresh sample.
module pwm_output_stage
  import wave_gen_pkg::*;
#(
  parameter int unsigned N_FRAC = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  pwm_output_stage_if.slave bus
);

  localparam int unsigned W = N_FRAC + 1;

  pwm_state_e   state_q, state_d;
  logic [W-1:0] duty_active_q, duty_active_d;
  logic [W-1:0] pending_q, pending_d;
  logic         pending_valid_q, pending_valid_d;
  logic         underrun_q, underrun_d;
  logic         req_q, req_d;
  logic         drain_q, drain_d;

  logic [W-1:0] duty_in_c;
  logic         wrap_c;

  assign duty_in_c = W'(to_duty(16'(bus.data_i), N_FRAC));

  pwm_core #(.W(W)) u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .run_i    (state_q == ST_RUN),
    .duty_i   (duty_active_q),
    .wrap_c_o (wrap_c),
    .pwm_o    (bus.pwm_o)
  );

  // Requests are registered: raised on the cycle before cnt returns to zero.
  always_comb begin
    state_d         = state_q;
    duty_active_d   = duty_active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    underrun_d      = underrun_q;
    req_d           = 1'b0;
    drain_d         = drain_q;

    unique case (state_q)
      ST_IDLE: begin
        drain_d = 1'b0;
        if (bus.enable_i) begin
          state_d         = ST_PRIME;
          underrun_d      = 1'b0;
          pending_valid_d = 1'b0;
          req_d           = 1'b1;
        end
      end

      ST_PRIME: begin
        if (!bus.enable_i) begin
          state_d = ST_IDLE;
        end else if (bus.data_valid_strobe_i) begin
          duty_active_d = duty_in_c;
          state_d       = ST_RUN;
          req_d         = 1'b1;
        end
      end

      ST_RUN: begin
        if (!bus.enable_i) drain_d = 1'b1;
        if (wrap_c) begin
          // Same-cycle strobe bypasses the buffer; otherwise use pending or repeat.
          if (bus.data_valid_strobe_i) begin
            duty_active_d = duty_in_c;
          end else if (pending_valid_q) begin
            duty_active_d = pending_q;
          end else begin
            underrun_d = 1'b1;
          end
          pending_valid_d = 1'b0;
          if (drain_q || !bus.enable_i) begin
            state_d = ST_IDLE;
            drain_d = 1'b0;
          end else begin
            req_d = 1'b1;
          end
        end else if (bus.data_valid_strobe_i) begin
          pending_d       = duty_in_c;
          pending_valid_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      duty_active_q   <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      underrun_q      <= 1'b0;
      req_q           <= 1'b0;
      drain_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      duty_active_q   <= duty_active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      underrun_q      <= underrun_d;
      req_q           <= req_d;
      drain_q         <= drain_d;
    end
  end

  assign bus.next_data_strobe_o = req_q;
  assign bus.underrun_o         = underrun_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Self-checking bench for pwm_output_stage: period-level reference model of
// duty, request pacing, buffering/bypass and sticky underrun.
module tb_pwm_output_stage;

  localparam int unsigned N_FRAC = 7;
  localparam int PER = 256;
  localparam int NONE = -1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pwm_output_stage_if #(.N_FRAC(N_FRAC)) bus ();

  pwm_output_stage #(.N_FRAC(N_FRAC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: duty of the running period, sticky underrun,
  // and whether a request is due at the first cycle of the next period.
  int cur_duty;
  bit m_und;
  bit m_req_next;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic int ref_duty(input int s);
    return s + 128;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prime(input int s, input int wait_cyc, input string tag);
    int extra;
    bus.enable_i = 1'b1;
    tick();
    chk({tag, " prime req"}, 32'(bus.next_data_strobe_o), 1);
    chk({tag, " prime und"}, 32'(bus.underrun_o), 0);
    m_und = 1'b0;
    extra = 0;
    for (int i = 0; i < wait_cyc; i++) begin
      tick();
      extra += int'(bus.next_data_strobe_o);
    end
    chk({tag, " prime extra req"}, 32'(extra), 0);
    bus.data_i              = 8'(s);
    bus.data_valid_strobe_i = 1'b1;
    tick();
    bus.data_valid_strobe_i = 1'b0;
    chk({tag, " first pwm"}, 32'(bus.pwm_o), 0);
    cur_duty   = ref_duty(s);
    m_req_next = 1'b1;
  endtask

  // One full period; entry and exit both observe the cycle at phase 0.
  task automatic run_period(input int ph1, input int s1, input int ph2, input int s2,
                            input int drop_ph, input int back_ph, input string tag);
    int hi, reqs, reqph, nxt;
    bit got_s;
    hi = 0; reqs = 0; reqph = NONE; nxt = cur_duty; got_s = 1'b0;
    for (int p = 0; p < PER; p++) begin
      if (bus.next_data_strobe_o) begin reqs++; reqph = p; end
      if (p > 0 && bus.pwm_o) hi++;
      bus.data_valid_strobe_i = 1'b0;
      if (p == ph1) begin
        bus.data_i = 8'(s1); bus.data_valid_strobe_i = 1'b1; nxt = ref_duty(s1); got_s = 1'b1;
      end
      if (p == ph2) begin
        bus.data_i = 8'(s2); bus.data_valid_strobe_i = 1'b1; nxt = ref_duty(s2); got_s = 1'b1;
      end
      bus.enable_i = (p >= drop_ph && p < back_ph) ? 1'b0 : 1'b1;
      tick();
    end
    if (bus.pwm_o) hi++;
    bus.data_valid_strobe_i = 1'b0;
    chk({tag, " high"}, 32'(hi), 32'(cur_duty));
    chk({tag, " reqs"}, 32'(reqs), m_req_next ? 32'd1 : 32'd0);
    chk({tag, " req phase"}, 32'(reqph), m_req_next ? 32'd0 : 32'(NONE));
    if (!got_s) m_und = 1'b1;
    cur_duty = nxt;
    chk({tag, " und"}, 32'(bus.underrun_o), 32'(m_und));
    m_req_next = (drop_ph >= PER);
  endtask

  task automatic rand_period(input string tag);
    int ph1, ph2, n;
    n   = $urandom_range(1, 2);
    ph1 = $urandom_range(0, PER - 1);
    ph2 = (n == 2) ? int'($urandom_range(ph1, PER - 1)) : NONE;
    run_period(ph1, int'($urandom_range(0, 255)) - 128, ph2,
               int'($urandom_range(0, 255)) - 128, PER, PER, tag);
  endtask

  initial begin
    int cnt_a, cnt_b;
    rst = 1'b1;
    bus.enable_i = 1'b0;
    bus.data_i = '0;
    bus.data_valid_strobe_i = 1'b0;
    m_und = 1'b0; m_req_next = 1'b0; cur_duty = 0;
    repeat (3) tick();
    chk("reset pwm", 32'(bus.pwm_o), 0);
    chk("reset req", 32'(bus.next_data_strobe_o), 0);
    chk("reset und", 32'(bus.underrun_o), 0);
    rst = 1'b0;
    tick();

    // Extremes and midpoint of the duty range
    prime(-128, 2, "p1");
    run_period($urandom_range(0, 255), 0, NONE, 0, PER, PER, "duty_min");
    run_period($urandom_range(0, 255), 127, NONE, 0, PER, PER, "duty_mid");
    rand_period("duty_max");

    // Missing samples repeat the duty and latch underrun
    run_period(NONE, 0, NONE, 0, PER, PER, "starve1");
    run_period(NONE, 0, NONE, 0, PER, PER, "starve2");
    rand_period("after_starve");

    // Boundary bypass, then overwrite inside a period
    run_period(10, 64, 255, -64, PER, PER, "bypass");
    run_period(100, 10, 200, 20, PER, PER, "overwrite");
    rand_period("after_ovw");

    for (int i = 0; i < 6; i++) rand_period("random");

    // Disable mid-period: finish, no further requests, idle low
    run_period(30, int'($urandom_range(0, 255)) - 128, NONE, 0, 100, PER, "drain");
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 5; i++) begin
      cnt_a += int'(bus.pwm_o);
      cnt_b += int'(bus.next_data_strobe_o);
      tick();
    end
    chk("idle pwm", 32'(cnt_a), 0);
    chk("idle req", 32'(cnt_b), 0);
    prime(int'($urandom_range(0, 255)) - 128, 0, "p2");
    rand_period("p2 run");

    // Re-enable during drain still drains, then re-primes
    run_period(20, 50, NONE, 0, 100, 150, "redrain");
    chk("redrain idle req", 32'(bus.next_data_strobe_o), 0);
    tick();
    chk("redrain prime req", 32'(bus.next_data_strobe_o), 1);
    chk("redrain und", 32'(bus.underrun_o), 0);
    bus.data_i = 8'(100);
    bus.data_valid_strobe_i = 1'b1;
    tick();
    bus.data_valid_strobe_i = 1'b0;
    cur_duty = ref_duty(100); m_req_next = 1'b1; m_und = 1'b0;
    run_period(NONE, 0, NONE, 0, PER, PER, "starve3");

    // Asynchronous reset mid-period, release with enable high
    repeat (50) tick();
    rst = 1'b1;
    #1;
    chk("midrst pwm", 32'(bus.pwm_o), 0);
    chk("midrst req", 32'(bus.next_data_strobe_o), 0);
    chk("midrst und", 32'(bus.underrun_o), 0);
    #2;
    rst = 1'b0;
    bus.enable_i = 1'b1;
    tick();
    chk("release req", 32'(bus.next_data_strobe_o), 1);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 6; i++) begin
      cnt_a += int'(bus.next_data_strobe_o);
      cnt_b += int'(bus.pwm_o) + int'(bus.underrun_o);
      tick();
    end
    chk("release req count", 32'(cnt_a), 1);
    chk("release pwm/und", 32'(cnt_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_output_stage.md
Name: pwm_output_stage

Overview:
- Downstream consumer of the sine generator: takes signed N_FRAC+1-bit samples and drives a single-bit PWM pin, one sample per PWM period.
- Paces the generator by issuing the one-cycle next-sample request strobe once per period.
- Double-buffers samples so a new value only takes effect at a period boundary.
- Flags underrun when no fresh sample has arrived by the end of a period.

Parameters:
- N_FRAC, 7: fractional bits of the sample; the sample is N_FRAC+1 bits, and the PWM period is 2^(N_FRAC+1) clock cycles.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-high.
- enable_i  in  1  run request; level-sensitive.
- data_i  in  N_FRAC+1  signed sample from the generator.
- data_valid_strobe_i  in  1  one-cycle strobe; data_i is valid in that cycle.
- next_data_strobe_o  out  1  one-cycle request to the generator for the next sample.
- pwm_o  out  1  PWM output, registered.
- underrun_o  out  1  sticky underrun flag.

Behaviour:
- Reset (async, rst_i=1) forces:
  - state=IDLE, cnt=0, duty_active=0, pending=0, pending_valid=0.
  - next_data_strobe_o=0, pwm_o=0, underrun_o=0.
  - Release is synchronous to clk_i.
  - Reset mid-period aborts immediately, with no completion of the current period.
- Duty conversion is offset binary: duty = {~data_i[N_FRAC], data_i[N_FRAC-1:0]}, unsigned, range 0..2^(N_FRAC+1)-1.
  - Examples for N_FRAC=7: -128→0, 0→128, 127→255.
- State machine, registered, three states:
  - IDLE: pwm_o=0 and cnt holds 0. When enable_i=1, go to PRIME, clear underrun_o, and assert next_data_strobe_o for the first PRIME cycle.
  - PRIME: wait indefinitely for data_valid_strobe_i. On a strobe, duty_active<=duty(data_i), cnt<=0, go to RUN. If enable_i drops while in PRIME, go to IDLE with no strobe issued.
  - RUN: cnt increments by 1 each cycle and wraps from 2^(N_FRAC+1)-1 to 0.
- next_data_strobe_o in RUN:
  - Asserted for exactly one cycle whenever cnt==0 and enable_i=1.
  - At most one request per period; never asserted in IDLE except the single PRIME-entry pulse.
- Sample capture in RUN: a data_valid_strobe_i sets pending<=duty(data_i) and pending_valid<=1.
  - A second strobe before the boundary overwrites pending; latest value wins; this is not an error.
- Period boundary, the RUN cycle with cnt==MAX:
  - If a strobe arrives in the same cycle, that sample is used directly (bypass).
  - Else if pending_valid=1, duty_active<=pending.
  - Else duty_active holds its value and underrun_o<=1 (sticky).
  - In all cases pending_valid<=0.
- Disable while in RUN: the current period completes. No request is issued at a cnt==0 that occurs after enable_i=0. At cnt==MAX with enable_i=0, go to IDLE. Re-enable during drain does not cancel the drain.
- pwm_o timing: pwm_o(t+1) = (state(t)==RUN) && (cnt(t) < duty_active(t)).
  - Exactly duty high cycles per period.
  - duty=0 keeps the pin constantly low; the maximum duty gives 2^(N_FRAC+1)-1 high cycles.
- Data strobes arriving in IDLE are ignored.
- underrun_o clears only on reset or on entry to PRIME.
- Latency: the first pwm_o high occurs 2 cycles after the priming data strobe, provided duty>0.

Decomposition:
- Shared package (wave_gen_pkg): state encoding (IDLE, PRIME, RUN) and the function/constant for PWM_PERIOD = 2^(N_FRAC+1). The offset-binary conversion lives here too, so the generator testbench can reuse it.
- One natural sub-module: pwm_core, containing the counter, comparator, registered pwm_o and the wrap/boundary flag. The top level holds the FSM, the sample buffer and the underrun logic.

Test Plan:
- Reset/prime: assert rst_i mid-stream, then release with enable_i=1. Required: pwm_o=0, underrun_o=0, and exactly one next_data_strobe_o in the cycle after release.
- Duty values: supply samples -128, 0 and 127 (N_FRAC=7) on successive periods. Required: high counts per period of 0, 128 and 255; one request per period, at cnt==0.
- Underrun: withhold the strobe for one period after the request. Required: underrun_o=1 from the next boundary; the previous duty is repeated; underrun_o stays 1 while RUN continues.
- Boundary bypass and overwrite:
  - Strobe 64 at cnt==10, then strobe -64 at cnt==255. Required: next period duty=64 (192-64 → 64 high cycles, i.e. high count 64).
  - Separately, strobes 10 then 20 mid-period. Required: duty uses 20 (148 high cycles).
- Disable mid-period: drop enable_i at cnt==100. Required: the period finishes with the correct high count, no further requests, then IDLE with pwm_o=0. Re-enabling clears underrun_o and issues a PRIME request.
